// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor.
//   sub_state_t : controller states (IDLE, BUSY, DONE)
//   clog2_min1  : ceil(log2(n)) clamped to at least 1, used to size counters
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } sub_state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit ripple-borrow subtractor: d = x - y - bi.
// Ports:
//   x, y : DIGIT-bit minuend / subtrahend digits
//   bi   : borrow in
//   d    : DIGIT-bit difference digit
//   bo   : borrow out of the most significant cell
module digit_subtractor #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  // Chain of full-subtractor cells, LSB first.
  always_comb begin : chain
    logic brw;
    brw = bi;
    d   = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ brw;
      brw  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw);
    end
    bo = brw;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor computing a - b - bin, DIGIT bits per clock,
// LSB digit first, with the borrow registered between digits.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : request, honoured only in IDLE or DONE
//   a, b     : WIDTH-bit operands, captured on an accepted start
//   bin      : borrow in, captured on an accepted start
//   busy     : digits being processed
//   done     : one-cycle pulse, result valid
//   diff     : WIDTH-bit result, held until the next operation completes
//   bout     : unsigned borrow out (a < b + bin)
//   ovf      : two's-complement overflow of a - b - bin
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned K  = WIDTH / DIGIT;
  localparam int unsigned CW = clog2_min1(K);

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] res_q, res_next;
  logic             borrow_q;
  logic             a_msb, b_msb;
  logic [DIGIT-1:0] dig_d;
  logic             dig_bo;
  logic             accept;
  logic             last;

  // Operands are shifted right each digit, so the active digit is always
  // in the low DIGIT bits.
  digit_subtractor #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x (a_sh[DIGIT-1:0]),
    .y (b_sh[DIGIT-1:0]),
    .bi(borrow_q),
    .d (dig_d),
    .bo(dig_bo)
  );

  always_comb begin
    accept   = start && ((state_q == IDLE) || (state_q == DONE));
    last     = (count_q == CW'(K - 1));
    res_next = res_q;
    res_next[count_q * DIGIT +: DIGIT] = dig_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    state_d = start ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
    busy = (state_q == BUSY);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      count_q  <= '0;
      a_sh     <= a;
      b_sh     <= b;
      res_q    <= '0;
      borrow_q <= bin;
      a_msb    <= a[WIDTH-1];
      b_msb    <= b[WIDTH-1];
    end else if (state_q == BUSY) begin
      count_q  <= count_q + CW'(1);
      a_sh     <= a_sh >> DIGIT;
      b_sh     <= b_sh >> DIGIT;
      res_q    <= res_next;
      borrow_q <= dig_bo;
      // Outputs are published only once the final digit is in.
      if (last) begin
        diff <= res_next;
        bout <= dig_bo;
        ovf  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8, DIGIT=2
  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  // WIDTH=4, DIGIT=1
  logic       start41 = 1'b0, bin41 = 1'b0;
  logic [3:0] a41 = '0, b41 = '0;
  logic       busy41, done41, bout41, ovf41;
  logic [3:0] diff41;

  // WIDTH=4, DIGIT=4
  logic       start44 = 1'b0, bin44 = 1'b0;
  logic [3:0] a44 = '0, b44 = '0;
  logic       busy44, done44, bout44, ovf44;
  logic [3:0] diff44;

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(4), .DIGIT(1)) u_dut41 (
    .clk(clk), .rst(rst), .start(start41), .a(a41), .b(b41), .bin(bin41),
    .busy(busy41), .done(done41), .diff(diff41), .bout(bout41), .ovf(ovf41)
  );

  serial_subtractor #(.WIDTH(4), .DIGIT(4)) u_dut44 (
    .clk(clk), .rst(rst), .start(start44), .a(a44), .b(b44), .bin(bin44),
    .busy(busy44), .done(done44), .diff(diff44), .bout(bout44), .ovf(ovf44)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Packed as {ovf, bout, diff[7:0]}.
  function automatic logic [31:0] model(input int unsigned w, input int unsigned ai,
                                        input int unsigned bi, input int unsigned ci);
    int unsigned m, d;
    logic bo, ov, sa, sb, sd;
    logic [31:0] r;
    m  = 1 << w;
    d  = (ai + 2 * m - bi - ci) % m;
    bo = (ai < bi + ci);
    sa = (ai >= m / 2);
    sb = (bi >= m / 2);
    sd = (d >= m / 2);
    ov = (sa != sb) && (sd != sa);
    r  = {22'b0, ov, bo, d[7:0]};
    return r;
  endfunction

  function automatic logic [31:0] obs8();
    return {22'b0, ovf8, bout8, diff8};
  endfunction

  // One full operation on the 8-bit instance with latency/busy checks.
  task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input string tag);
    int lat, busy_n;
    @(negedge clk);
    a8 = ai; b8 = bi; bin8 = ci; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0; busy_n = 0;
    while (!done8 && lat < 20) begin
      if (busy8) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " busy cycles"}, 32'(busy_n), 32'd4);
    check({tag, " busy&done"}, {31'b0, busy8 & done8}, 32'd0);
    check({tag, " result"}, obs8(), model(8, ai, bi, 32'(ci)));
  endtask

  task automatic op4(input int sel, input logic [3:0] ai, input logic [3:0] bi, input logic ci,
                     output logic [31:0] res, output int lat);
    @(negedge clk);
    if (sel == 1) begin a41 = ai; b41 = bi; bin41 = ci; start41 = 1'b1; end
    else          begin a44 = ai; b44 = bi; bin44 = ci; start44 = 1'b1; end
    @(posedge clk); #1;
    start41 = 1'b0; start44 = 1'b0;
    lat = 0;
    while (!((sel == 1) ? done41 : done44) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sel == 1) res = {22'b0, ovf41, bout41, 4'b0, diff41};
    else          res = {22'b0, ovf44, bout44, 4'b0, diff44};
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] res;
    logic [7:0]  ra, rb;
    logic        rc;
    int lat, bad, bad41, bad44, lat_bad41, lat_bad44;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset 8", {busy8, done8, bout8, ovf8, diff8}, 32'd0);
    check("reset 41", {busy41, done41, bout41, ovf41, diff41}, 32'd0);
    check("reset 44", {busy44, done44, bout44, ovf44, diff44}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    op8(8'h5A, 8'h3C, 1'b0, "5A-3C");
    check("5A-3C diff", {24'b0, diff8}, 32'h1E);
    op8(8'h00, 8'h01, 1'b0, "00-01");
    check("00-01 bout", {31'b0, bout8}, 32'd1);
    op8(8'h80, 8'h01, 1'b0, "80-01");
    check("80-01 ovf", {31'b0, ovf8}, 32'd1);
    op8(8'h10, 8'h0F, 1'b1, "10-0F-1");
    op8(8'h7F, 8'hFF, 1'b0, "7F-FF");
    check("7F-FF diff", {24'b0, diff8}, 32'h80);

    // Random operations
    for (int i = 0; i < 20; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), "rand");

    // Start pulsed mid-operation must be ignored
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignored start latency", 32'(lat), 32'd4);
    check("ignored start diff", obs8(), model(8, 8'h05, 8'h03, 0));

    // Reset mid-operation
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h5E; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid reset outputs", {busy8, done8, bout8, ovf8, diff8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post reset idle", {busy8, done8}, 32'd0);
    op8(8'h33, 8'hA7, 1'b1, "after reset");

    // Start held high: one result every K+1 = 5 cycles
    @(negedge clk);
    start8 = 1'b1;
    for (int r = 0; r < 6; r++) begin
      if (r > 0) @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      a8 = ra; b8 = rb; bin8 = rc;
      @(posedge clk); #1;
      bad = 0;
      if (done8 || !busy8) bad++;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        @(posedge clk); #1;
        if (done8 || !busy8) bad++;
      end
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      check("b2b busy phase", 32'(bad), 32'd0);
      check("b2b done pulse", {31'b0, done8}, 32'd1);
      check("b2b result", obs8(), model(8, ra, rb, 32'(rc)));
    end
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
    check("b2b idle after", {busy8, done8}, 32'd0);

    // Exhaustive 4-bit sweeps
    bad41 = 0; bad44 = 0; lat_bad41 = 0; lat_bad44 = 0;
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          op4(1, 4'(ai), 4'(bi), 1'(ci), res, lat);
          check("w4d1 result", res, model(4, ai, bi, ci));
          if (lat != 4) lat_bad41++;
          op4(4, 4'(ai), 4'(bi), 1'(ci), res, lat);
          check("w4d4 result", res, model(4, ai, bi, ci));
          if (lat != 1) lat_bad44++;
        end
    check("w4d1 latency errors", 32'(lat_bad41), 32'd0);
    check("w4d4 latency errors", 32'(lat_bad44), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor computing `a - b - bin` on WIDTH-bit operands, DIGIT bits per clock, with a registered borrow carried between digits. It is the sequential successor to the single-bit half/full subtractor cells in the arithmetic lab set. It sits behind a simple start/busy/done handshake and reports unsigned borrow-out and signed overflow.

## Interface
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- `WIDTH`, default 8: operand and result width. Must be ≥1.
- `DIGIT`, default 2: bits processed per cycle. Must be ≥1 and WIDTH % DIGIT == 0. Digit count K = WIDTH/DIGIT.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `a`  in  WIDTH  minuend, captured on accepted start
- `b`  in  WIDTH  subtrahend, captured on accepted start
- `bin`  in  1  borrow-in, captured on accepted start
- `busy`  out  1  high while digits are being processed
- `done`  out  1  one-cycle pulse when the result becomes valid
- `diff`  out  WIDTH  result, registered and held until the next accepted start completes
- `bout`  out  1  unsigned borrow-out (1 when a < b + bin)
- `ovf`  out  1  two's-complement overflow of a − b − bin

## Operation
- FSM states and transitions:
  - IDLE → BUSY on start=1.
  - BUSY → BUSY while count < K−1.
  - BUSY → DONE after the digit with count = K−1.
  - DONE → BUSY on start=1, otherwise DONE → IDLE.
- Accepted start loads a, b and bin into shift/borrow registers and sets count=0. Inputs are ignored afterwards.
- Each BUSY cycle:
  - Digit `count` (LSB-first) is `a_d − b_d − borrow_reg`, done with a DIGIT-bit ripple-borrow chain.
  - Result bits go into the working result register at positions [count*DIGIT +: DIGIT].
  - borrow_reg takes that digit's borrow-out, and count increments.
- On the BUSY→DONE edge:
  - diff takes the full working result.
  - bout = final borrow.
  - ovf = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]), using the captured operands.
- diff, bout and ovf change only on that edge (or reset), so they never show partial results.
- start while BUSY is ignored; no queuing.
- Reset at any time, including mid-operation: state IDLE, count=0, busy=0, done=0, diff=0, bout=0, ovf=0, internal registers 0. The first start after reset behaves normally.

## Timing
- Reset values: busy=0, done=0, diff=0, bout=0, ovf=0.
- Start sampled at edge E0. busy=1 from E0 through EK (K edges). done=1 between EK and EK+1, and diff, bout and ovf are valid from EK.
- Latency K cycles. With back-to-back starts (start held high in DONE), throughput is one result per K+1 cycles.
- busy and done are never high together.
- DIGIT=WIDTH gives K=1: done arrives one edge after BUSY entry.
- Arithmetic is modulo 2^WIDTH.

## Structure
- Package `sub_pkg`:
  - state enum `sub_state_t` {IDLE, BUSY, DONE}
  - helper function for ceil-log2 of K, used to size the count register (minimum width 1)
- Sub-module `digit_subtractor`: combinational, parameter DIGIT; ports x, y, bi in, d, bo out. It is a ripple chain of full-subtractor cells and is instantiated once in the datapath.
- Top level contains the FSM, count, operand shift registers, borrow register and output registers.

## Test plan
- WIDTH=8, DIGIT=2: a=8'h5A, b=8'h3C, bin=0 → done exactly 4 edges after start; diff=8'h1E, bout=0, ovf=0; busy high for 4 cycles.
- a=8'h00, b=8'h01, bin=0 → diff=8'hFF, bout=1, ovf=0. Also a=8'h80, b=8'h01 → diff=8'h7F, bout=0, ovf=1.
- a=8'h10, b=8'h0F, bin=1 → diff=8'h00, bout=0, ovf=0. Then a=8'h7F, b=8'hFF, bin=0 → diff=8'h80, bout=1, ovf=1.
- Start with a=8'h05, b=8'h03; pulse start again with a=8'hFF mid-BUSY → the second start is ignored and the result is diff=8'h02. Assert rst two cycles into a new operation → all outputs 0 the next cycle and busy=0; a subsequent start completes correctly.
- Start held high continuously → done pulses every 5 cycles and each result matches the operands captured at the corresponding accept.
- WIDTH=4, DIGIT=1 and WIDTH=4, DIGIT=4: exhaustive sweep of all a, b and bin values → diff, bout and ovf match the reference model (a−b−bin) mod 16, with latency 4 and 1 respectively.
